apb_slave_regbank: RTL

Parametrised APB slave register bank, the successor to the fixed four-register zero-wait slave. It adds:
- configurable register count and data width;
- byte-lane write strobes;
- a programmable wait-state counter driving PREADY;
- PSLVERR for bad accesses;
- per-register read-only (hardware-owned) mode with a hardware-side read/write interface.

It sits behind the APB master/interconnect. PSEL is already base-decoded upstream.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_strb_reg.sv | 34 +++
 rtl/apb_slave_regbank.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave register bank: FSM states and
// address-decode helpers.
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    localparam int APB_MAX_WAIT = 15;

    // Byte-address bits below the register word boundary.
    function automatic int apb_align(input int data_width);
        return (data_width == 32) ? 2 : (data_width == 16) ? 1 : 0;
    endfunction

    function automatic int apb_idx_w(input int num_regs);
        return (num_regs <= 1) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/apb_strb_reg.sv
// One DATA_WIDTH register with independent byte-lane write enables and
// asynchronous active-low reset to zero.
module apb_strb_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   q
);

    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (be[b]) begin
                data_d[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// Parametrised APB slave register bank with byte strobes, programmable wait
// states, PSLVERR on bad accesses and hardware-owned read-only registers.
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [0:0]                     dbg_state
);

    localparam int ALIGN = apb_align(DATA_WIDTH);
    localparam int IDX_W = apb_idx_w(NUM_REGS);
    localparam int OFF_W = ADDR_WIDTH - ALIGN;
    localparam int NB    = DATA_WIDTH / 8;

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
        $error("apb_slave_regbank: DATA_WIDTH must be 8, 16 or 32");
    end
    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_nr
        $error("apb_slave_regbank: NUM_REGS must be 1..64");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > APB_MAX_WAIT) begin : g_bad_ws
        $error("apb_slave_regbank: WAIT_STATES out of range");
    end

    // Handshake: a transfer completes in the ACCESS-state cycle where
    // PSEL & PENABLE & PREADY are all high; side effects land on that edge.
    apb_slv_state_e        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [OFF_W-1:0]      offset;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  ro_sel;
    logic                  err;
    logic                  access_done;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data;

    assign offset   = PADDR[ADDR_WIDTH-1:ALIGN];
    assign idx      = offset[IDX_W-1:0];
    assign in_range = offset < OFF_W'(NUM_REGS);

    if (ALIGN > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^PADDR[ALIGN-1:0];
    end

    always_comb begin
        ro_sel = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                ro_sel = RO_MASK[i];
            end
        end
    end

    assign err         = !in_range || (PWRITE && ro_sel);
    assign access_done = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign commit      = access_done && PWRITE && !err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (PENABLE) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse_d[i] = commit && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign rd_src[i]                          = hw_ro_in[i*DATA_WIDTH +: DATA_WIDTH];
            assign reg_q[i*DATA_WIDTH +: DATA_WIDTH]  = '0;
        end else begin : g_rw
            logic [NB-1:0]         be;
            logic [DATA_WIDTH-1:0] q;
            logic                  unused_hw;

            assign be = {NB{commit && (idx == IDX_W'(i))}} & PSTRB;

            apb_strb_reg #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_reg (
                .clk  (PCLK),
                .rst_n(PRESETn),
                .be   (be),
                .wdata(PWDATA),
                .q    (q)
            );

            assign rd_src[i]                         = q;
            assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q;
            assign unused_hw                         = ^hw_ro_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // hw_ro_in flows straight through here, so RO reads see the live value.
    always_comb begin
        rd_data = '0;
        if (access_done && !PWRITE && !err) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IDX_W'(i)) begin
                    rd_data = rd_src[i];
                end
            end
        end
    end

    assign PRDATA    = rd_data;
    assign PREADY    = (cnt_q == 4'd0);
    assign PSLVERR   = access_done && err;
    assign wr_pulse  = wr_pulse_q;
    assign dbg_state = state_q;

endmodule
